// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction at a time, with load alignment/extension
// and a valid/ready response to writeback. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  lsu_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          is_store;
  logic [2:0]    funct3;
  logic [1:0]    offset;

  logic          op_bad;
  logic          misalign;
  logic [3:0]    strb;
  logic [31:0]   wd;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign cnt_inc = cnt + 1'b1;

  // Stores only have B/H/W widths; loads additionally have BU/HU.
  always_comb begin
    op_bad = 1'b0;
    if (lsu_op[3]) begin
      op_bad = (lsu_op[2:0] > 3'd2);
    end else begin
      case (lsu_op[2:0])
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_bad = 1'b0;
        default:                                op_bad = 1'b1;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (lsu_op[1:0] == 2'b01)      misalign = addr[0];
    else if (lsu_op[1:0] == 2'b10) misalign = (addr[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    strb = 4'b0000;
    wd   = 32'h0;
    if (lsu_op[3]) begin
      case (lsu_op[1:0])
        2'b00: begin
          strb = 4'b0001 << addr[1:0];
          wd   = {4{wdata[7:0]}};
        end
        2'b01: begin
          strb = 4'b0011 << {addr[1], 1'b0};
          wd   = {2{wdata[15:0]}};
        end
        default: begin
          strb = 4'b1111;
          wd   = wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel  = mem_rdata[8*offset +: 8];
    half_sel  = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
    if (is_store) load_data = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
      cnt       <= '0;
      is_store  <= 1'b0;
      funct3    <= 3'b000;
      offset    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op_bad || misalign) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= 32'h0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= lsu_op[3];
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= strb;
              mem_wdata <= wd;
              cnt       <= '0;
              is_store  <= lsu_op[3];
              funct3    <= lsu_op[2:0];
              offset    <= addr[1:0];
            end
          end
        end
        REQ: begin
          // An ack arriving on the limit cycle still completes normally.
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= load_data;
          end else if (ACK_TIMEOUT != 0 && cnt_inc == CW'(ACK_TIMEOUT)) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= 32'h0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= 32'h0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized + directed bench for lsu against a behavioural model of the load/store rules.
module tb_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  lsu_op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_pass = 0;
  int txn_id = 0;

  lsu #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .lsu_op(lsu_op), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL txn%0d %s got=%h exp=%h", txn_id, tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          err_now;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  // Reference: widths, lanes and extension computed with plain arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] w, input logic [31:0] r);
    exp_t        e;
    int unsigned off  = a % 4;
    int unsigned f    = op[2:0];
    bit          st   = op[3];
    int unsigned b;
    int unsigned h;
    e.err_now = st ? (f > 2) : !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
`ifdef MISALIGN_TRAP_EN
    if ((f % 4) == 1 && (a % 2) != 0) e.err_now = 1;
    if ((f % 4) == 2 && off != 0)     e.err_now = 1;
`endif
    e.strb = 0;
    e.wd   = 0;
    e.rd   = 0;
    if (st) begin
      if (f == 0)      begin e.strb = 4'(1 << off);       e.wd = (w % 256) * 32'h01010101; end
      else if (f == 1) begin e.strb = 4'(3 << (off & 2)); e.wd = (w % 65536) * 32'h00010001; end
      else             begin e.strb = 4'hF;               e.wd = w; end
    end else begin
      b = (r >> (8 * off)) % 256;
      h = (r >> (16 * (off / 2))) % 65536;
      case (f)
        0: e.rd = (b >= 128) ? (b + 32'hFFFFFF00) : b;
        4: e.rd = b;
        1: e.rd = (h >= 32768) ? (h + 32'hFFFF0000) : h;
        5: e.rd = h;
        default: e.rd = r;
      endcase
    end
    return e;
  endfunction

  // k = cycles of mem_req before ack (k >= TO means no ack), hold = cycles of out_ready=0.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] r, input int k, input int hold);
    exp_t        e;
    bit          tmo;
    logic [31:0] exp_rd;
    logic        exp_err;
    txn_id++;
    e   = model(op, a, w, r);
    tmo = !e.err_now && (k >= TO);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; lsu_op = op; addr = a; wdata = w;
    step();
    in_valid = 0; lsu_op = 4'($urandom); addr = $urandom; wdata = $urandom;
    check("in_ready_busy", in_ready, 0);
    if (!e.err_now) begin
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      check("mem_we", mem_we, op[3]);
      check("mem_wstrb", mem_wstrb, e.strb);
      check("mem_wdata", mem_wdata, e.wd);
      for (int i = 0; i < (tmo ? TO : k); i++) begin
        check("mem_req_wait", mem_req, 1);
        check("mem_addr_stable", mem_addr, {a[31:2], 2'b00});
        check("out_valid_wait", out_valid, 0);
        mem_rdata = $urandom;
        step();
      end
      if (!tmo) begin
        check("mem_req_ack", mem_req, 1);
        mem_ack = 1; mem_rdata = r;
        step();
        mem_ack = 0; mem_rdata = $urandom;
      end
    end
    check("mem_req_resp", mem_req, 0);
    exp_err = e.err_now || tmo;
    exp_rd  = (exp_err || op[3]) ? 32'h0 : e.rd;
    out_ready = 0;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_rdata", out_rdata, exp_rd);
      check("hold_err", out_err, exp_err);
      check("hold_in_ready", in_ready, 0);
      mem_ack = 1'($urandom_range(0, 1));
      step();
      mem_ack = 0;
    end
    check("out_valid", out_valid, 1);
    check("out_rdata", out_rdata, exp_rd);
    check("out_err", out_err, exp_err);
    out_ready = 1;
    step();
    out_ready = 0;
    check("out_valid_done", out_valid, 0);
    check("in_ready_done", in_ready, 1);
    $display("txn%0d op=%h addr=%h wdata=%h rdata=%h k=%0d hold=%0d -> out_rdata=%h out_err=%0d",
             txn_id, op, a, w, r, k, hold, exp_rd, exp_err);
  endtask

  logic [3:0] op_tab [13] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA,
                               4'h3, 4'h6, 4'h7, 4'hC, 4'hD};

  initial begin
    rst_n = 0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_rdata", out_rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_mem_req", mem_req, 0);

    run_txn(4'h0, 32'h80000003, 32'h0, 32'h85FFFFFF, 3, 0);   // LB
    run_txn(4'h4, 32'h80000003, 32'h0, 32'h85FFFFFF, 3, 0);   // LBU
    run_txn(4'h9, 32'h80000002, 32'h1234ABCD, 32'h0, 1, 0);   // SH
    run_txn(4'h2, 32'h80000010, 32'h0, 32'hDEADBEEF, TO, 1);  // LW timeout
    run_txn(4'h1, 32'h80000001, 32'h0, 32'h0000F00F, 0, 0);   // LH odd address
    run_txn(4'h2, 32'h80000020, 32'h0, 32'hCAFEF00D, 0, 5);   // backpressure
    run_txn(4'h3, 32'h80000024, 32'h0, 32'h0, 0, 0);          // bad funct3, back-to-back

    // Reset while a request is outstanding, then a late ack.
    txn_id++;
    in_valid = 1; lsu_op = 4'h2; addr = 32'h00000100;
    step();
    in_valid = 0;
    check("rst_mid_req_before", mem_req, 1);
    rst_n = 0;
    #1;
    check("rst_mid_req_async", mem_req, 0);
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    rst_n = 1;
    step();
    step();
    mem_ack = 0;
    check("late_ack_out_valid", out_valid, 0);
    check("late_ack_in_ready", in_ready, 1);
    check("late_ack_mem_req", mem_req, 0);
    $display("txn%0d reset during REQ with late ack", txn_id);

    for (int n = 0; n < 40; n++) begin
      run_txn(op_tab[$urandom_range(0, 12)], $urandom, $urandom, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
